// File: rtl/mix_column_iter.sv
// Iterative AES MixColumns / InvMixColumns engine with valid/ready handshakes.
// COLS_PER_CYCLE columns are mixed per clock. A per-block bypass passes the
// state through unchanged, which is what the final round needs.
module mix_column_iter #(
    parameter int COLS_PER_CYCLE = 1,
    parameter bit DEC_EN         = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             enc_dec,
    input  logic             bypass,
    input  logic [0:15][7:0] data_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [0:15][7:0] data_out,
    output logic             busy
);
    // Handshakes: a block moves on a rising edge where valid && ready are both high.
    // in_ready does not depend on in_valid. out_valid stays high, with data_out
    // held stable, until out_ready takes the block.

    localparam int STEPS = 4 / COLS_PER_CYCLE;
    localparam int SW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           st_q, st_d;
    logic [SW-1:0]    step_q, step_d;
    logic [0:15][7:0] data_q, data_d;
    logic             enc_q, enc_d;
    logic [0:15][7:0] mix_src, mixed;
    logic             enc_in, mix_enc, accept;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (8'h1B & {8{x[7]}});
    endfunction

    // One column, row 0 in the top byte. enc=1 forward matrix, enc=0 inverse.
    function automatic logic [31:0] mix_col(input logic [31:0] a, input logic enc);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] d0, d1, d2, d3;      // 2*a
        logic [7:0] q0, q1, q2, q3;      // 4*a
        logic [7:0] o0, o1, o2, o3;      // 8*a
        logic [7:0] b0, b1, b2, b3;
        a0 = a[31:24]; a1 = a[23:16]; a2 = a[15:8]; a3 = a[7:0];
        d0 = xtime(a0); d1 = xtime(a1); d2 = xtime(a2); d3 = xtime(a3);
        q0 = xtime(d0); q1 = xtime(d1); q2 = xtime(d2); q3 = xtime(d3);
        o0 = xtime(q0); o1 = xtime(q1); o2 = xtime(q2); o3 = xtime(q3);
        if (enc) begin
            b0 = d0 ^ (d1 ^ a1) ^ a2 ^ a3;
            b1 = a0 ^ d1 ^ (d2 ^ a2) ^ a3;
            b2 = a0 ^ a1 ^ d2 ^ (d3 ^ a3);
            b3 = (d0 ^ a0) ^ a1 ^ a2 ^ d3;
        end else begin
            // E = 8^4^2, B = 8^2^1, D = 8^4^1, 9 = 8^1
            b0 = (o0 ^ q0 ^ d0) ^ (o1 ^ d1 ^ a1) ^ (o2 ^ q2 ^ a2) ^ (o3 ^ a3);
            b1 = (o0 ^ a0) ^ (o1 ^ q1 ^ d1) ^ (o2 ^ d2 ^ a2) ^ (o3 ^ q3 ^ a3);
            b2 = (o0 ^ q0 ^ a0) ^ (o1 ^ a1) ^ (o2 ^ q2 ^ d2) ^ (o3 ^ d3 ^ a3);
            b3 = (o0 ^ d0 ^ a0) ^ (o1 ^ q1 ^ a1) ^ (o2 ^ a2) ^ (o3 ^ q3 ^ d3);
        end
        return {b0, b1, b2, b3};
    endfunction

    // With a single step the whole block is mixed on the accept edge, so the
    // mixers read the input port directly and the engine sustains one block per cycle.
    assign enc_in   = DEC_EN ? enc_dec : 1'b1;
    assign mix_src  = (STEPS == 1) ? data_in : data_q;
    assign mix_enc  = (STEPS == 1) ? enc_in : enc_q;

    assign in_ready  = (st_q == IDLE) || ((st_q == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (st_q == DONE);
    assign busy      = (st_q != IDLE);
    assign data_out  = data_q;

    // Mix the column group picked by the step counter; other columns pass through.
    always_comb begin
        logic [1:0]  col;
        logic [31:0] cin;
        logic [31:0] cout;
        mixed = mix_src;
        col   = '0;
        cin   = '0;
        cout  = '0;
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            col  = 2'(int'(step_q) * COLS_PER_CYCLE + k);
            cin  = {mix_src[{col, 2'd0}], mix_src[{col, 2'd1}],
                    mix_src[{col, 2'd2}], mix_src[{col, 2'd3}]};
            cout = mix_col(cin, mix_enc);
            mixed[{col, 2'd0}] = cout[31:24];
            mixed[{col, 2'd1}] = cout[23:16];
            mixed[{col, 2'd2}] = cout[15:8];
            mixed[{col, 2'd3}] = cout[7:0];
        end
    end

    // Next-state logic: IDLE -> RUN -> DONE, with accepts allowed from IDLE and DONE.
    always_comb begin
        st_d   = st_q;
        step_d = step_q;
        data_d = data_q;
        enc_d  = enc_q;
        case (st_q)
            IDLE: begin
            end
            RUN: begin
                data_d = mixed;
                if (step_q == SW'(STEPS - 1)) begin
                    st_d   = DONE;
                    step_d = '0;
                end else begin
                    step_d = step_q + SW'(1);
                end
            end
            DONE: begin
                if (out_ready && !in_valid) begin
                    st_d = IDLE;
                end
            end
            default: begin
                st_d   = IDLE;
                step_d = '0;
            end
        endcase
        if (accept) begin
            enc_d  = enc_in;
            step_d = '0;
            if (bypass) begin
                data_d = data_in;
                st_d   = DONE;
            end else if (STEPS == 1) begin
                data_d = mixed;
                st_d   = DONE;
            end else begin
                data_d = data_in;
                st_d   = RUN;
            end
        end
    end

    // State, step counter, block register and mode register; reset discards any block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q   <= IDLE;
            step_q <= '0;
            data_q <= '0;
            enc_q  <= 1'b0;
        end else begin
            st_q   <= st_d;
            step_q <= step_d;
            data_q <= data_d;
            enc_q  <= enc_d;
        end
    end

endmodule

// File: tb/tb_mix_column_iter.sv
// Bench for mix_column_iter: three instances (1, 2 and 4 columns per cycle),
// each with its own driver, expected queue and monitor, plus a final report.
module tb_mix_column_iter;

    typedef logic [0:15][7:0] blk_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit fin [3];

    task automatic chk(input string nm, input int gi, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s inst%0d: got %h want %h", nm, gi, got, want);
        end
    endtask

    // Field multiply: carry-less product reduced modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
        for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'(9'h11B) << (i - 8));
        return p[7:0];
    endfunction

    // Circulant matrix entry k positions right of the diagonal.
    function automatic logic [7:0] coef(input bit enc, input int k);
        case (k)
            0:       return enc ? 8'h02 : 8'h0E;
            1:       return enc ? 8'h03 : 8'h0B;
            2:       return enc ? 8'h01 : 8'h0D;
            default: return enc ? 8'h01 : 8'h09;
        endcase
    endfunction

    function automatic blk_t model(input blk_t d, input bit enc, input bit byp);
        blk_t r;
        logic [7:0] acc;
        r = d;
        if (!byp) begin
            for (int c = 0; c < 4; c++) begin
                for (int row = 0; row < 4; row++) begin
                    acc = 8'h00;
                    for (int j = 0; j < 4; j++) acc = acc ^ gmul(coef(enc, (j - row + 4) % 4), d[4 * c + j]);
                    r[4 * c + row] = acc;
                end
            end
        end
        return r;
    endfunction

    function automatic blk_t rand_blk();
        blk_t d;
        for (int i = 0; i < 16; i++) d[i] = 8'($urandom_range(0, 255));
        return d;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : u
        localparam int CPC   = 1 << g;
        localparam int STEPS = 4 / CPC;
        localparam int SPACE = (STEPS == 1) ? 1 : STEPS + 1;

        logic rst, in_valid, in_ready, enc_dec, bypass, out_valid, out_ready, busy;
        logic or_drv, rr, rand_rdy;
        blk_t data_in, data_out;
        blk_t exp_q[$];
        int   lat_q[$];
        blk_t held;
        bit   seen = 1'b0;
        int   cyc = 0;
        int   last_acc = 0;

        assign out_ready = rand_rdy ? rr : or_drv;

        mix_column_iter #(.COLS_PER_CYCLE(CPC), .DEC_EN(1'b1)) dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .enc_dec   (enc_dec),
            .bypass    (bypass),
            .data_in   (data_in),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .data_out  (data_out),
            .busy      (busy)
        );

        always @(posedge clk) cyc <= cyc + 1;

        always @(posedge clk) begin
            #1;
            rr = ($urandom_range(0, 9) < 6);
        end

        // Monitor: busy vs pending blocks, first-valid timing, hold stability, data order.
        always @(negedge clk) begin
            if (rst) begin
                seen = 1'b0;
            end else begin
                chk("busy", g, busy, exp_q.size() != 0);
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_out inst%0d: out_valid=1 with no block pending", g);
                    end else begin
                        if (!seen) begin
                            chk("latency", g, cyc, lat_q[0]);
                            held = data_out;
                            seen = 1'b1;
                        end else begin
                            chk("hold", g, data_out, held);
                        end
                        if (out_ready) begin
                            chk("data", g, data_out, exp_q[0]);
                            void'(exp_q.pop_front());
                            void'(lat_q.pop_front());
                            seen = 1'b0;
                        end
                    end
                end
            end
        end

        task automatic send(input blk_t d, input bit enc, input bit byp, input blk_t e);
            int n;
            n = 0;
            data_in  = d;
            enc_dec  = enc;
            bypass   = byp;
            in_valid = 1'b1;
            @(negedge clk);
            while (!in_ready && n < 200) begin
                n++;
                @(negedge clk);
            end
            if (!in_ready) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout inst%0d: in_ready=0 want 1 within 200 cycles", g);
            end else begin
                @(posedge clk);
                #1;
                exp_q.push_back(e);
                lat_q.push_back(cyc + ((byp || STEPS == 1) ? 0 : STEPS));
                last_acc = cyc;
            end
        endtask

        // Drop in_valid and scramble the other inputs, which must no longer matter.
        task automatic idle();
            in_valid = 1'b0;
            data_in  = rand_blk();
            enc_dec  = 1'($urandom_range(0, 1));
            bypass   = 1'($urandom_range(0, 1));
        endtask

        task automatic wait_drain();
            int n;
            n = 0;
            while (exp_q.size() != 0 && n < 300) begin
                n++;
                @(negedge clk);
            end
            if (exp_q.size() != 0) begin
                checks++;
                errors++;
                $display("FAIL drain_timeout inst%0d: %0d blocks pending want 0", g, exp_q.size());
                exp_q.delete();
                lat_q.delete();
            end
            @(posedge clk);
            #1;
        endtask

        initial begin
            blk_t d, e;
            bit   enc, byp;
            int   a_first, n;
            rst = 1'b1; in_valid = 1'b0; enc_dec = 1'b0; bypass = 1'b0;
            data_in = '0; or_drv = 1'b0; rand_rdy = 1'b0;
            repeat (3) @(posedge clk);
            #1 rst = 1'b0;
            @(negedge clk);
            chk("rst_in_ready", g, in_ready, 1);
            chk("rst_out_valid", g, out_valid, 0);
            chk("rst_busy", g, busy, 0);
            chk("rst_data_out", g, data_out, 0);
            @(posedge clk);
            #1;

            // Known-answer blocks
            or_drv = 1'b1;
            d = {8'hdb, 8'h13, 8'h53, 8'h45, {12{8'h01}}};
            e = {8'h8e, 8'h4d, 8'ha1, 8'hbc, {12{8'h01}}};
            send(d, 1'b1, 1'b0, e);
            idle();
            wait_drain();
            d = {8'h8e, 8'h4d, 8'ha1, 8'hbc, 8'h9f, 8'hdc, 8'h58, 8'h9d, {8{8'h01}}};
            e = {8'hdb, 8'h13, 8'h53, 8'h45, 8'hf2, 8'h0a, 8'h22, 8'h5c, {8{8'h01}}};
            send(d, 1'b0, 1'b0, e);
            idle();
            wait_drain();

            // Bypass in both modes
            d = rand_blk();
            send(d, 1'b0, 1'b1, d);
            idle();
            d = rand_blk();
            send(d, 1'b1, 1'b1, d);
            idle();
            wait_drain();

            // Backpressure: hold in DONE for 10 cycles while in_valid pulses
            or_drv = 1'b0;
            d = rand_blk();
            send(d, 1'b1, 1'b0, model(d, 1'b1, 1'b0));
            idle();
            n = 0;
            while (!out_valid && n < 50) begin
                n++;
                @(negedge clk);
            end
            chk("bp_out_valid", g, out_valid, 1);
            repeat (10) begin
                @(posedge clk);
                #1;
                in_valid = 1'($urandom_range(0, 1));
                data_in  = rand_blk();
                bypass   = 1'($urandom_range(0, 1));
                @(negedge clk);
                chk("bp_in_ready", g, in_ready, 0);
            end
            @(posedge clk);
            #1;
            idle();
            or_drv = 1'b1;
            wait_drain();

            // Back-to-back burst with out_ready held high
            a_first = 0;
            for (int i = 0; i < 8; i++) begin
                d   = rand_blk();
                enc = 1'($urandom_range(0, 1));
                send(d, enc, 1'b0, model(d, enc, 1'b0));
                if (i == 0) a_first = last_acc;
            end
            idle();
            chk("burst_spacing", g, last_acc - a_first, 7 * SPACE);
            wait_drain();

            // Random blocks, modes, gaps and downstream readiness
            rand_rdy = 1'b1;
            for (int i = 0; i < 40; i++) begin
                d   = rand_blk();
                enc = 1'($urandom_range(0, 1));
                byp = ($urandom_range(0, 3) == 0);
                send(d, enc, byp, model(d, enc, byp));
                if ($urandom_range(0, 3) == 0) begin
                    idle();
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    #1;
                end
            end
            idle();
            wait_drain();
            rand_rdy = 1'b0;

            // Asynchronous reset with a block in flight
            or_drv = 1'b0;
            d = rand_blk();
            send(d, 1'b1, 1'b0, model(d, 1'b1, 1'b0));
            idle();
            repeat (2) @(posedge clk);
            #2 rst = 1'b1;
            #1;
            chk("arst_out_valid", g, out_valid, 0);
            chk("arst_data_out", g, data_out, 0);
            chk("arst_busy", g, busy, 0);
            exp_q.delete();
            lat_q.delete();
            @(negedge clk);
            @(posedge clk);
            #1 rst = 1'b0;
            @(negedge clk);
            chk("post_rst_in_ready", g, in_ready, 1);
            chk("post_rst_out_valid", g, out_valid, 0);
            @(posedge clk);
            #1;
            or_drv = 1'b1;
            d = rand_blk();
            send(d, 1'b0, 1'b0, model(d, 1'b0, 1'b0));
            idle();
            wait_drain();

            fin[g] = 1'b1;
        end
    end

    initial begin
        int n;
        n = 0;
        while (!(fin[0] && fin[1] && fin[2]) && n < 20000) begin
            n++;
            @(posedge clk);
        end
        if (!(fin[0] && fin[1] && fin[2])) begin
            checks++;
            errors++;
            $display("FAIL global_timeout: done flags %0d%0d%0d want 111", fin[0], fin[1], fin[2]);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
